// File: rtl/vga_sync_gen.sv
// VGA timing generator with latency-matched sync/colour output stage.
// Optional colour-bar pattern: define VGA_SYNC_TESTPAT_EN.
module vga_sync_gen #(
  parameter int   H_VISIBLE     = 1280,
  parameter int   H_FRONT       = 48,
  parameter int   H_SYNC        = 112,
  parameter int   H_BACK        = 248,
  parameter int   V_VISIBLE     = 1024,
  parameter int   V_FRONT       = 1,
  parameter int   V_SYNC        = 3,
  parameter int   V_BACK        = 38,
  parameter logic HSYNC_ACTIVE  = 1'b1,
  parameter logic VSYNC_ACTIVE  = 1'b1,
  parameter int   CNT_W         = 11,
  parameter int   PIXEL_LATENCY = 2,
  parameter int   R_W           = 3,
  parameter int   G_W           = 3,
  parameter int   B_W           = 2
) (
  input  logic                     VGACLK,
  input  logic                     RST_IN,
  input  logic [R_W+G_W+B_W-1:0]   PIXEL_DATA,
  input  logic                     TESTPAT_SEL,
  output logic [CNT_W-1:0]         POS_X,
  output logic [CNT_W-1:0]         POS_Y,
  output logic                     REQ_EN,
  output logic                     FRAME_START,
  output logic                     LINE_START,
  output logic                     DISPLAY_EN,
  output logic [R_W-1:0]           R,
  output logic [G_W-1:0]           G,
  output logic [B_W-1:0]           B,
  output logic                     HSYNC,
  output logic                     VSYNC
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int PD_W    = R_W + G_W + B_W;

  localparam logic [CNT_W-1:0] HV    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] VV    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HT_M1 = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VT_M1 = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_B  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_E  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_B  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_E  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

`ifdef VGA_SYNC_TESTPAT_EN
  localparam int PW = 3 + CNT_W;
`else
  localparam int PW = 3;
`endif

  logic [CNT_W-1:0] pos_x_q, pos_x_d;
  logic [CNT_W-1:0] pos_y_q, pos_y_d;
  logic             req_raw, hs_raw, vs_raw;
  logic [PW-1:0]    pipe_in, pipe_out;
  logic             disp_q, disp_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [PD_W-1:0]  rgb_q, rgb_d;

  always_comb begin
    pos_x_d = pos_x_q + 1'b1;
    pos_y_d = pos_y_q;
    if (pos_x_q == HT_M1) begin
      pos_x_d = '0;
      pos_y_d = (pos_y_q == VT_M1) ? '0 : pos_y_q + 1'b1;
    end
    if (RST_IN) begin
      pos_x_d = '0;
      pos_y_d = '0;
    end
  end

  always_ff @(posedge VGACLK) begin
    pos_x_q <= pos_x_d;
    pos_y_q <= pos_y_d;
  end

  // Request-side decodes are forced low while reset is held.
  assign req_raw = !RST_IN && (pos_x_q < HV) && (pos_y_q < VV);
  assign hs_raw  = (pos_x_q >= HS_B) && (pos_x_q <= HS_E);
  assign vs_raw  = (pos_y_q >= VS_B) && (pos_y_q <= VS_E);

  assign POS_X       = pos_x_q;
  assign POS_Y       = pos_y_q;
  assign REQ_EN      = req_raw;
  assign FRAME_START = !RST_IN && (pos_x_q == '0) && (pos_y_q == '0);
  assign LINE_START  = !RST_IN && (pos_x_q == '0) && (pos_y_q < VV);

`ifdef VGA_SYNC_TESTPAT_EN
  assign pipe_in = {pos_x_q, vs_raw, hs_raw, req_raw};
`else
  assign pipe_in = {vs_raw, hs_raw, req_raw};
`endif

  generate
    if (PIXEL_LATENCY == 0) begin : g_nodly
      assign pipe_out = pipe_in;
    end else begin : g_dly
      logic [PW-1:0] pipe_q [PIXEL_LATENCY];
      logic [PW-1:0] pipe_d [PIXEL_LATENCY];

      always_comb begin
        pipe_d[0] = pipe_in;
        for (int i = 1; i < PIXEL_LATENCY; i++)
          pipe_d[i] = pipe_q[i-1];
        if (RST_IN)
          for (int i = 0; i < PIXEL_LATENCY; i++)
            pipe_d[i] = '0;
      end

      always_ff @(posedge VGACLK) begin
        for (int i = 0; i < PIXEL_LATENCY; i++)
          pipe_q[i] <= pipe_d[i];
      end

      assign pipe_out = pipe_q[PIXEL_LATENCY-1];
    end
  endgenerate

`ifdef VGA_SYNC_TESTPAT_EN
  logic [CNT_W-1:0] x_dly;
  logic [CNT_W+2:0] x8;
  logic [2:0]       bar;
  logic [PD_W-1:0]  bar_rgb;

  assign x_dly = pipe_out[PW-1:3];
  assign x8    = {x_dly, 3'b000};

  // bar = floor(x*8 / H_VISIBLE) without a divider
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (x8 >= (CNT_W+3)'(k * H_VISIBLE))
        bar = 3'(k);
  end

  assign bar_rgb = {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
`else
  logic unused_testpat;
  assign unused_testpat = TESTPAT_SEL;
`endif

  always_comb begin
    disp_d = pipe_out[0];
    hs_d   = pipe_out[1];
    vs_d   = pipe_out[2];
    rgb_d  = disp_d ? PIXEL_DATA : '0;
`ifdef VGA_SYNC_TESTPAT_EN
    if (TESTPAT_SEL && disp_d)
      rgb_d = bar_rgb;
`endif
    if (RST_IN) begin
      disp_d = 1'b0;
      hs_d   = 1'b0;
      vs_d   = 1'b0;
      rgb_d  = '0;
    end
  end

  always_ff @(posedge VGACLK) begin
    disp_q <= disp_d;
    hs_q   <= hs_d;
    vs_q   <= vs_d;
    rgb_q  <= rgb_d;
  end

  assign DISPLAY_EN = disp_q;
  assign R          = rgb_q[PD_W-1 -: R_W];
  assign G          = rgb_q[B_W +: G_W];
  assign B          = rgb_q[B_W-1:0];
  assign HSYNC      = hs_q ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
  assign VSYNC      = vs_q ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a 16x8 timing, latency 2.
// Colour-bar checks apply when VGA_SYNC_TESTPAT_EN is defined.
module tb_vga_sync_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pix;
  logic        sel;
  logic [10:0] pos_x, pos_y;
  logic        req_en, frame_start, line_start, disp_en;
  logic [2:0]  r, g;
  logic [1:0]  b;
  logic        hsync, vsync;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;
  bit tp      = 1'b0;

  int hs_line0, hs_first, fs_cnt, ls_cnt, vs_cnt, r7_cnt, r7_at;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1),
    .CNT_W(11), .PIXEL_LATENCY(2),
    .R_W(3), .G_W(3), .B_W(2)
  ) dut (
    .VGACLK(clk), .RST_IN(rst),
    .PIXEL_DATA(pix), .TESTPAT_SEL(sel),
    .POS_X(pos_x), .POS_Y(pos_y),
    .REQ_EN(req_en), .FRAME_START(frame_start),
    .LINE_START(line_start), .DISPLAY_EN(disp_en),
    .R(r), .G(g), .B(b),
    .HSYNC(hsync), .VSYNC(vsync)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h",
               tag, n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] data_of(int q);
    if (q < 0) return 8'h00;
    if (q == 3) return 8'hE0;
    if ((q % 16) >= 8) return 8'hFF;
    return 8'h00;
  endfunction

  function automatic logic [7:0] bar_of(int x);
    logic [7:0] v;
    v[7:5] = x[2] ? 3'b111 : 3'b000;
    v[4:2] = x[1] ? 3'b111 : 3'b000;
    v[1:0] = x[0] ? 2'b11  : 2'b00;
    return v;
  endfunction

  task automatic check_cycle();
    int ex, ey, q, qx, qy;
    logic e_vis, e_hs, e_vs;
    logic [7:0] e_rgb;
    ex = n % 16;
    ey = (n / 16) % 8;
    check("pos_x", 32'(pos_x), ex);
    check("pos_y", 32'(pos_y), ey);
    check("req_en", 32'(req_en), 32'(ex < 8 && ey < 4));
    check("frame_start", 32'(frame_start), 32'(ex == 0 && ey == 0));
    check("line_start", 32'(line_start), 32'(ex == 0 && ey < 4));
    q = n - 3;
    e_vis = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = 8'h00;
    if (q >= 0) begin
      qx = q % 16;
      qy = (q / 16) % 8;
      e_vis = (qx < 8) && (qy < 4);
      e_hs  = (qx >= 10) && (qx <= 12);
      e_vs  = (qy >= 5) && (qy <= 6);
      if (e_vis) e_rgb = tp ? bar_of(qx) : data_of(q);
    end
    check("display_en", 32'(disp_en), 32'(e_vis));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("rgb", 32'({r, g, b}), 32'(e_rgb));
    if (hsync && n < 16) hs_line0++;
    if (hsync && hs_first < 0) hs_first = n;
    if (frame_start) fs_cnt++;
    if (line_start) ls_cnt++;
    if (vsync) vs_cnt++;
    if (r == 3'b111 && !tp) begin
      r7_cnt++;
      r7_at = n;
    end
  endtask

  task automatic run(int cnt);
    for (int i = 0; i < cnt; i++) begin
      check_cycle();
      pix = data_of(n - 2);
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; pix = 8'h00; sel = 1'b0;
    hs_line0 = 0; hs_first = -1; fs_cnt = 0;
    ls_cnt = 0; vs_cnt = 0; r7_cnt = 0; r7_at = -1;

    repeat (5) begin
      tick();
      check("rst_pos", 32'({pos_x, pos_y}), 0);
      check("rst_out", 32'({hsync, vsync, r, g, b, req_en,
                            frame_start, line_start, disp_en}), 0);
    end

    rst = 1'b0;
    #1;
    check("rel_pos", 32'({pos_x, pos_y}), 0);
    check("rel_frame_start", 32'(frame_start), 1);
    check("rel_req_en", 32'(req_en), 1);
    check("rel_line_start", 32'(line_start), 1);

    run(256);
    check("hs_line0_len", hs_line0, 3);
    check("hs_first_cycle", hs_first, 13);
    check("frame_start_cnt", fs_cnt, 2);
    check("line_start_cnt", ls_cnt, 8);
    check("vsync_cnt", vs_cnt, 64);
    check("red_pulse_cnt", r7_cnt, 1);
    check("red_pulse_at", r7_at, 6);

    run(108);
    check_cycle();
    check("mid_pos", 32'({pos_x, pos_y}), 32'({11'd12, 11'd6}));
    rst = 1'b1;
    tick();
    check("mid_rst_pos", 32'({pos_x, pos_y}), 0);
    check("mid_rst_sync", 32'({hsync, vsync}), 0);
    check("mid_rst_out", 32'({r, g, b, disp_en, req_en}), 0);

    rst = 1'b0;
    #1;
    n = 0;
    check("re_frame_start", 32'(frame_start), 1);
    sel = 1'b1;
`ifdef VGA_SYNC_TESTPAT_EN
    tp = 1'b1;
`endif
    run(48);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
